// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer with synchronous active-low reset to RESET_VAL.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver, LSB first, registered byte output with done strobe.
// Define UART_RX_PARITY_EN to add a parity bit after the data and the parity_err output.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low (blocked after a break until the line goes high)
// START  | counting to mid start bit, rejects glitches
// DATA   | sampling DBIT data bits at mid-bit
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | counting to mid stop bit, then publish the frame
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic            parity_err
`endif
);

    localparam int SCW = ($clog2(SB_TICK) > 5) ? $clog2(SB_TICK) : 5;
    localparam int NW  = $clog2(DBIT);

    localparam logic [SCW-1:0] S_MID       = SCW'(MID_TICK);
    localparam logic [SCW-1:0] S_BIT_LAST  = SCW'(OVERSAMPLE - 1);
    localparam logic [SCW-1:0] S_STOP_LAST = SCW'(SB_TICK - 1);
    localparam logic [NW-1:0]  N_LAST      = NW'(DBIT - 1);

    logic            rx_s;
    rx_state_e       state_q, state_d;
    logic [SCW-1:0]  s_cnt_q, s_cnt_d;
    logic [NW-1:0]   n_cnt_q, n_cnt_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            frame_err_q, frame_err_d;
    logic            brk_q, brk_d;
`ifdef UART_RX_PARITY_EN
    logic            par_bit_q, par_bit_d;
    logic            parity_err_q, parity_err_d;
`else
    logic            unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD[0];
`endif

    sync_2ff #(.RESET_VAL(1'b1)) u_sync_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
        par_bit_d = par_bit_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s && !brk_q) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_q == S_MID) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SCW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == S_BIT_LAST) begin
                        shift_d = {rx_s, shift_q[DBIT-1:1]};
                        s_cnt_d = '0;
                        if (n_cnt_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_cnt_d = n_cnt_q + NW'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SCW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_cnt_q == S_BIT_LAST) begin
                        par_bit_d = rx_s;
                        s_cnt_d   = '0;
                        state_d   = STOP;
                    end else begin
                        s_cnt_d = s_cnt_q + SCW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == S_STOP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + SCW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        done_d      = (state_q == STOP) && s_tick && (s_cnt_q == S_STOP_LAST);
        dout_d      = done_d ? shift_q : dout_q;
        frame_err_d = done_d ? ~rx_s : frame_err_q;
`ifdef UART_RX_PARITY_EN
        parity_err_d = done_d ? (^{shift_q, par_bit_q} ^ PARITY_ODD[0]) : parity_err_q;
`endif
        // A low stop bit means a break may be in progress; wait for the line to go high.
        brk_d = brk_q;
        if (done_d && !rx_s) begin
            brk_d = 1'b1;
        end else if (rx_s) begin
            brk_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_cnt_q     <= '0;
            n_cnt_q     <= '0;
            shift_q     <= '0;
            dout_q      <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            brk_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            s_cnt_q     <= s_cnt_d;
            n_cnt_q     <= n_cnt_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
            brk_q       <= brk_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: s_tick every 4 clks, one bit = 64 clks.
module tb_uart_rx;

    logic       clk;
    logic       rst_n;
    logic       s_tick;
    logic       rx;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int double_cnt = 0;
    logic prev_done = 1'b0;
    logic [7:0] log_dout[$];
    logic       log_ferr[$];
    logic       log_perr[$];

    uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_tick       (s_tick),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        int tdiv;
        tdiv   = 0;
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            tdiv   = (tdiv + 1) % 4;
            s_tick = (tdiv == 0);
        end
    end

    // Record every done pulse and flag any two-cycle-wide pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_done_tick) begin
                if (prev_done) double_cnt++;
                log_dout.push_back(dout);
                log_ferr.push_back(frame_err);
`ifdef UART_RX_PARITY_EN
                log_perr.push_back(parity_err);
`else
                log_perr.push_back(1'b0);
`endif
            end
            prev_done = rx_done_tick;
        end
    end

    task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int unsigned log_d(input int i);
        return (i < log_dout.size()) ? int'(log_dout[i]) : 32'hdead;
    endfunction

    function automatic int unsigned log_f(input int i);
        return (i < log_ferr.size()) ? int'(log_ferr[i]) : 32'hdead;
    endfunction

    function automatic int unsigned log_p(input int i);
        return (i < log_perr.size()) ? int'(log_perr[i]) : 32'hdead;
    endfunction

    task automatic send_bit(input logic b);
        rx = b;
        wait_clks(64);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^data) ^ par_flip);
`else
        if (par_flip) send_bit(1'b1);
`endif
        send_bit(1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        wait_clks(4);
        chk("rst_dout", dout, 0);
        chk("rst_done", rx_done_tick, 0);
        chk("rst_ferr", frame_err, 0);
`ifdef UART_RX_PARITY_EN
        chk("rst_perr", parity_err, 0);
`endif
        rst_n = 1'b1;
        wait_clks(20);

        send_frame(8'hA5, 1'b0);
        wait_clks(64);
        chk("a5_cnt", log_dout.size(), 1);
        chk("a5_dout", log_d(0), 8'hA5);
        chk("a5_ferr", log_f(0), 0);

        // 4-tick low glitch must be rejected at mid start bit
        rx = 1'b0;
        wait_clks(16);
        rx = 1'b1;
        wait_clks(192);
        chk("glitch_cnt", log_dout.size(), 1);
        chk("glitch_dout", dout, 8'hA5);

        send_frame(8'h55, 1'b0);
        send_frame(8'h3C, 1'b0);
        wait_clks(64);
        chk("b2b_cnt", log_dout.size(), 3);
        chk("b2b_dout0", log_d(1), 8'h55);
        chk("b2b_ferr0", log_f(1), 0);
        chk("b2b_dout1", log_d(2), 8'h3C);
        chk("b2b_ferr1", log_f(2), 0);

        rx = 1'b0;
        wait_clks(12 * 64);
        chk("brk_cnt", log_dout.size(), 4);
        chk("brk_dout", log_d(3), 0);
        chk("brk_ferr", log_f(3), 1);
        rx = 1'b1;
        wait_clks(128);
        chk("brk_after_cnt", log_dout.size(), 4);
        chk("brk_hold_ferr", frame_err, 1);

        // Abort 0xFF in the middle of data bit 3
        send_bit(1'b0);
        rx = 1'b1;
        wait_clks(3 * 64 + 32);
        rst_n = 1'b0;
        wait_clks(1);
        chk("midrst_dout", dout, 0);
        chk("midrst_done", rx_done_tick, 0);
        chk("midrst_ferr", frame_err, 0);
        wait_clks(1);
        rst_n = 1'b1;
`ifdef UART_RX_PARITY_EN
        wait_clks(32 + 4 * 64 + 64 + 64);
`else
        wait_clks(32 + 4 * 64 + 64);
`endif
        chk("abort_cnt", log_dout.size(), 4);
        send_frame(8'h81, 1'b0);
        wait_clks(64);
        chk("post_rst_cnt", log_dout.size(), 5);
        chk("post_rst_dout", log_d(4), 8'h81);
        chk("post_rst_ferr", log_f(4), 0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'hA5, 1'b0);
        wait_clks(64);
        chk("par_ok_cnt", log_dout.size(), 6);
        chk("par_ok_perr", log_p(5), 0);
        send_frame(8'hA5, 1'b1);
        wait_clks(64);
        chk("par_bad_cnt", log_dout.size(), 7);
        chk("par_bad_perr", log_p(6), 1);
        chk("par_bad_dout", log_d(6), 8'hA5);
`endif

        chk("pulse_width", double_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
